kbd_scanner: RTL and testbench

Scans a physical PET keyboard matrix from the FPGA, debounces it, and exposes the 10×8 row image plus a sticky change flag to the Raspberry Pi over the Pi register window at $E820–$E82A. It is the producer side of the keyboard path: the Pi reads the physical matrix here, while the existing PIA1 keyboard interception consumes the matrix the Pi writes at $E800–$E809. Rows are driven active-low one at a time; columns are active-low with pull-ups.

---
 rtl/kbd_scanner_if.sv | 10 +
 rtl/kbd_scanner.sv | 121 ++++++++++++
 tb/tb_kbd_scanner.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/kbd_scanner_if.sv
// Pi register-window read port for the keyboard scanner.
// The Pi side drives address and strobe; the scanner returns the read data.
interface kbd_scanner_if;
  logic [15:0] pi_addr;
  logic        pi_read_strobe;
  logic [7:0]  pi_data_out;

  modport master (output pi_addr, output pi_read_strobe, input pi_data_out);
  modport slave  (input pi_addr, input pi_read_strobe, output pi_data_out);
endinterface

// File: rtl/kbd_scanner.sv
// PET keyboard matrix scanner: walks active-low rows, debounces the column image
// per row, and serves the row image plus a sticky change flag to the Pi.
//
// state    | meaning
// S_IDLE   | rows released, row and settle counter held at 0
// S_SETTLE | current row driven, waiting for the columns to settle
// S_SAMPLE | current row still driven, columns captured and debounced
module kbd_scanner #(
  parameter int ROWS          = 10,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic            clk,
  input  logic            reset_b,
  input  logic            scan_enable,
  output logic [ROWS-1:0] kbd_row_b,
  input  logic [7:0]      kbd_col_b,
  kbd_scanner_if.slave    pi,
  output logic            key_changed
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE} state_t;

  localparam int              CW        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]      ROW_LAST  = 4'(ROWS - 1);
  localparam logic [15:0]     ADDR_STAT = 16'hE82A;
  localparam logic [11:0]     ADDR_PAGE = 12'hE82;

  state_t        state, state_nx;
  logic [3:0]    row;
  logic [CW-1:0] cnt;
  logic [7:0]    col_s1, col_s2;
  logic [7:0]    raw [ROWS];
  logic [7:0]    deb [ROWS];
  logic          sample_en;
  logic          change_evt;
  logic          status_rd;
  logic          row_rd;

  always_ff @(posedge clk) begin
    if (!reset_b) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    sample_en = 1'b0;
    case (state)
      S_IDLE: begin
        if (scan_enable) state_nx = S_SETTLE;
      end
      S_SETTLE: begin
        if (!scan_enable)        state_nx = S_IDLE;
        else if (cnt == CNT_LAST) state_nx = S_SAMPLE;
      end
      S_SAMPLE: begin
        // the capture always completes, even if scanning is being dropped
        sample_en = 1'b1;
        state_nx  = scan_enable ? S_SETTLE : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    kbd_row_b = '1;
    if (state != S_IDLE) kbd_row_b[row] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      row <= '0;
      cnt <= '0;
    end else if (state_nx == S_IDLE) begin
      row <= '0;
      cnt <= '0;
    end else if (state == S_SAMPLE) begin
      row <= (row == ROW_LAST) ? 4'd0 : row + 4'd1;
      cnt <= '0;
    end else if (state == S_SETTLE) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A new row image is accepted only when two consecutive scans agree.
  assign change_evt = sample_en && (col_s2 == raw[row]) && (col_s2 != deb[row]);
  assign status_rd  = pi.pi_read_strobe && (pi.pi_addr == ADDR_STAT);
  assign row_rd     = pi.pi_read_strobe && (pi.pi_addr[15:4] == ADDR_PAGE) &&
                      (pi.pi_addr[3:0] <= ROW_LAST);

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      col_s1         <= 8'hFF;
      col_s2         <= 8'hFF;
      key_changed    <= 1'b0;
      pi.pi_data_out <= 8'hFF;
      for (int i = 0; i < ROWS; i++) begin
        raw[i] <= 8'hFF;
        deb[i] <= 8'hFF;
      end
    end else begin
      col_s1 <= kbd_col_b;
      col_s2 <= col_s1;

      if (sample_en) begin
        raw[row] <= col_s2;
        if (change_evt) deb[row] <= col_s2;
      end

      if (change_evt)     key_changed <= 1'b1;
      else if (status_rd) key_changed <= 1'b0;

      if (pi.pi_read_strobe) begin
        if (status_rd)   pi.pi_data_out <= {key_changed, 3'b000, row};
        else if (row_rd) pi.pi_data_out <= deb[pi.pi_addr[3:0]];
        else             pi.pi_data_out <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_kbd_scanner.sv
// Scoreboard bench for kbd_scanner: a scan-position model predicts row drive,
// debounced image and flag; reads are queued and checked by a separate monitor.
module tb_kbd_scanner;
  localparam int ROWS   = 10;
  localparam int SETTLE = 64;
  localparam int PER    = SETTLE + 1;
  localparam int SCAN   = ROWS * PER;

  logic            clk = 1'b0;
  logic            reset_b = 1'b0;
  logic            scan_enable = 1'b0;
  logic [ROWS-1:0] kbd_row_b;
  logic [7:0]      kbd_col_b;
  logic            key_changed;
  logic [7:0]      keys [ROWS];

  kbd_scanner_if pi();

  kbd_scanner #(.ROWS(ROWS), .SETTLE_CYCLES(SETTLE)) dut (
    .clk         (clk),
    .reset_b     (reset_b),
    .scan_enable (scan_enable),
    .kbd_row_b   (kbd_row_b),
    .kbd_col_b   (kbd_col_b),
    .pi          (pi),
    .key_changed (key_changed)
  );

  always #5 clk = ~clk;

  // physical matrix: a pressed key pulls its column low while its row is driven
  always_comb begin
    kbd_col_b = 8'hFF;
    for (int r = 0; r < ROWS; r++)
      if (!kbd_row_b[r]) kbd_col_b = kbd_col_b & ~keys[r];
  end

  int          total = 0;
  int          bad = 0;
  bit          m_idle = 1'b1;
  int          m_pos = 0;
  logic [7:0]  m_raw [ROWS];
  logic [7:0]  m_deb [ROWS];
  bit          m_kc = 1'b0;
  logic [7:0]  exp_q [$];
  bit          rnd_rd = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] expect_read(input logic [15:0] a, input int r);
    if (a == 16'hE82A) return {m_kc, 3'b000, 4'(r)};
    if (a >= 16'hE820 && a < 16'hE820 + ROWS) return m_deb[int'(a - 16'hE820)];
    return 8'hFF;
  endfunction

  // Effect of the coming clock edge, from the inputs presented before it.
  task automatic model_edge();
    logic [7:0] nw;
    int r;
    bit evt;
    if (!reset_b) begin
      m_idle = 1'b1;
      m_pos  = 0;
      m_kc   = 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        m_raw[i] = 8'hFF;
        m_deb[i] = 8'hFF;
      end
      return;
    end
    r   = m_idle ? 0 : m_pos / PER;
    evt = 1'b0;
    if (pi.pi_read_strobe) exp_q.push_back(expect_read(pi.pi_addr, r));
    if (!m_idle && (m_pos % PER) == PER - 1) begin
      nw = ~keys[r];
      if (nw == m_raw[r] && nw != m_deb[r]) begin
        m_deb[r] = nw;
        evt = 1'b1;
      end
      m_raw[r] = nw;
    end
    if (evt) m_kc = 1'b1;
    else if (pi.pi_read_strobe && pi.pi_addr == 16'hE82A) m_kc = 1'b0;
    if (m_idle) begin
      if (scan_enable) begin
        m_idle = 1'b0;
        m_pos  = 0;
      end
    end else if (!scan_enable) begin
      m_idle = 1'b1;
      m_pos  = 0;
    end else begin
      m_pos = (m_pos + 1) % SCAN;
    end
  endtask

  task automatic tick();
    logic [ROWS-1:0] er;
    model_edge();
    @(posedge clk);
    #1;
    er = '1;
    if (!m_idle) er[m_pos / PER] = 1'b0;
    check("row_drive", 16'(kbd_row_b), 16'(er));
    check("key_changed", 16'(key_changed), 16'(m_kc));
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 16'hE820 + 16'($urandom_range(0, ROWS - 1));
      1:       return 16'hE82A;
      2:       return 16'hE830;
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (rnd_rd) begin
        pi.pi_read_strobe = ($urandom_range(0, 5) == 0);
        pi.pi_addr        = rand_addr();
      end else begin
        pi.pi_read_strobe = 1'b0;
      end
      tick();
    end
    pi.pi_read_strobe = 1'b0;
  endtask

  task automatic wait_at(input int row, input int phase);
    int n = 0;
    pi.pi_read_strobe = 1'b0;
    while (m_idle || m_pos != row * PER + phase) begin
      if (n > SCAN + PER) begin
        check("wait_timeout", 16'(n), 16'(SCAN + PER));
        return;
      end
      tick();
      n++;
    end
  endtask

  task automatic do_read(input logic [15:0] a);
    pi.pi_read_strobe = 1'b1;
    pi.pi_addr        = a;
    tick();
    pi.pi_read_strobe = 1'b0;
  endtask

  logic       rd_valid = 1'b0;
  logic       rst_hit = 1'b0;
  logic [7:0] held = 8'hFF;
  logic [7:0] mon_e;

  always @(posedge clk) begin
    rd_valid <= pi.pi_read_strobe && reset_b;
    rst_hit  <= !reset_b;
  end

  always @(negedge clk) begin
    if (rst_hit) held = 8'hFF;
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check("read_unexpected", 16'(pi.pi_data_out), 16'h0100);
      end else begin
        mon_e = exp_q.pop_front();
        check("read_data", 16'(pi.pi_data_out), 16'(mon_e));
        held = mon_e;
      end
    end else begin
      check("data_hold", 16'(pi.pi_data_out), 16'(held));
    end
  end

  initial begin
    for (int i = 0; i < ROWS; i++) keys[i] = 8'h00;
    pi.pi_read_strobe = 1'b0;
    pi.pi_addr        = 16'h0000;

    // reset with scanning requested, then one idle-keyboard scan plus wrap
    scan_enable = 1'b1;
    reset_b     = 1'b0;
    tick();
    tick();
    reset_b = 1'b1;
    run(SCAN + PER + 5);
    for (int a = 0; a <= ROWS; a++) do_read(16'hE820 + 16'(a));

    // column 3 on row 4 held through two scans
    wait_at(3, 10);
    keys[4] = 8'h08;
    run(2 * SCAN);
    do_read(16'hE824);
    do_read(16'hE82A);
    do_read(16'hE82A);

    // one-sample glitch on row 5, column 0
    wait_at(5, 10);
    keys[5] = 8'h01;
    wait_at(6, 10);
    keys[5] = 8'h00;
    run(2 * SCAN);
    do_read(16'hE825);
    do_read(16'hE82A);

    // release row 4 and press row 2; status read lands on row 4's qualifying sample
    wait_at(3, 10);
    keys[4] = 8'h00;
    keys[2] = 8'h81;
    wait_at(4, 10);
    run(SCAN / 2);
    wait_at(4, PER - 1);
    do_read(16'hE82A);
    do_read(16'hE830);
    run(2 * SCAN);
    do_read(16'hE822);
    do_read(16'hE824);

    // drop scanning mid-settle on row 7, then restart
    wait_at(7, 30);
    scan_enable = 1'b0;
    tick();
    run(20);
    do_read(16'hE822);
    do_read(16'hE82A);
    scan_enable = 1'b1;
    run(2 * PER + 3);
    do_read(16'hE822);

    // reset mid-scan with keys latched
    wait_at(8, 20);
    reset_b = 1'b0;
    tick();
    reset_b = 1'b1;
    for (int a = 0; a < ROWS; a++) do_read(16'hE820 + 16'(a));
    do_read(16'hE830);
    do_read(16'hE82A);
    keys[2] = 8'h00;

    // randomized keys and background reads
    rnd_rd = 1'b1;
    for (int it = 0; it < 10; it++) begin
      wait_at($urandom_range(0, ROWS - 1), 10);
      keys[$urandom_range(0, ROWS - 1)] = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      run($urandom_range(100, 1400));
    end
    rnd_rd = 1'b0;
    for (int a = 0; a <= ROWS; a++) do_read(16'hE820 + 16'(a));
    run(4);
    check("queue_drain", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
